// File: rtl/ctrl_pkg.sv
// Shared encodings, opcode match patterns and per-stage control bundles for
// the pipelined LEGv8 control unit.
package ctrl_pkg;

  localparam int OPC_W      = 11;
  localparam int ALUOP_BITS = 3;
  localparam int SEXT_BITS  = 3;

  localparam logic [ALUOP_BITS-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_BITS-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_BITS-1:0] ALU_AND   = 3'b010;
  localparam logic [ALUOP_BITS-1:0] ALU_ORR   = 3'b011;
  localparam logic [ALUOP_BITS-1:0] ALU_LSR   = 3'b100;
  localparam logic [ALUOP_BITS-1:0] ALU_LSL   = 3'b101;
  localparam logic [ALUOP_BITS-1:0] ALU_PASSB = 3'b110;

  localparam logic [SEXT_BITS-1:0] SEXT_I     = 3'b000;
  localparam logic [SEXT_BITS-1:0] SEXT_D     = 3'b001;
  localparam logic [SEXT_BITS-1:0] SEXT_SHAMT = 3'b010;
  localparam logic [SEXT_BITS-1:0] SEXT_CB    = 3'b011;
  localparam logic [SEXT_BITS-1:0] SEXT_B     = 3'b100;

  // Patterns are value/care pairs; a 0 in the care mask is a don't-care bit.
  localparam logic [OPC_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OP_ADDI = 11'b10010001000;
  localparam logic [OPC_W-1:0] OP_SUBI = 11'b11010001000;
  localparam logic [OPC_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [OPC_W-1:0] OP_LSR  = 11'b11010011010;
  localparam logic [OPC_W-1:0] OP_LSL  = 11'b11010011011;
  localparam logic [OPC_W-1:0] OP_CBZ  = 11'b10110100000;
  localparam logic [OPC_W-1:0] OP_B    = 11'b00010100000;

  localparam logic [OPC_W-1:0] CARE_FULL = 11'b11111111111;
  localparam logic [OPC_W-1:0] CARE_I    = 11'b11111111110;
  localparam logic [OPC_W-1:0] CARE_CB   = 11'b11111111000;
  localparam logic [OPC_W-1:0] CARE_B    = 11'b11111100000;

  // {branch, ubranch, memread, memwrite, memtoreg, regwrite}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_RW   = 6'b000001;
  localparam logic [5:0] F_LD   = 6'b001011;
  localparam logic [5:0] F_ST   = 6'b000100;
  localparam logic [5:0] F_CB   = 6'b100000;
  localparam logic [5:0] F_B    = 6'b010000;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  typedef struct packed {
    logic     branch;
    logic     ubranch;
    logic     memread;
    logic     memwrite;
    wb_ctrl_t wb;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  alusrc;
    logic [ALUOP_BITS-1:0] aluop;
    logic [SEXT_BITS-1:0]  sext;
    logic                  illegal;
    mem_ctrl_t             mem;
  } ex_ctrl_t;

  typedef struct packed {
    logic     reg2loc;
    ex_ctrl_t ex;
  } id_ctrl_t;

  localparam wb_ctrl_t  WB_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam id_ctrl_t  ID_BUBBLE  = '0;

  function automatic logic opc_is(input logic [OPC_W-1:0] op,
                                  input logic [OPC_W-1:0] val,
                                  input logic [OPC_W-1:0] care);
    return (op & care) == val;
  endfunction

  function automatic id_ctrl_t ctrl_word(input logic                  r2l,
                                         input logic                  asrc,
                                         input logic [ALUOP_BITS-1:0] aluop,
                                         input logic [SEXT_BITS-1:0]  sext,
                                         input logic [5:0]            flags);
    id_ctrl_t c;
    c                    = ID_BUBBLE;
    c.reg2loc            = r2l;
    c.ex.alusrc          = asrc;
    c.ex.aluop           = aluop;
    c.ex.sext            = sext;
    c.ex.mem.branch      = flags[5];
    c.ex.mem.ubranch     = flags[4];
    c.ex.mem.memread     = flags[3];
    c.ex.mem.memwrite    = flags[2];
    c.ex.mem.wb.memtoreg = flags[1];
    c.ex.mem.wb.regwrite = flags[0];
    return c;
  endfunction

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// ID-stage inputs and per-stage control outputs of the pipelined control unit.
interface ctrl_pipe_unit_if #(
  parameter int OPCODE_W = ctrl_pkg::OPC_W,
  parameter int REG_W    = 5,
  parameter int ALUOP_W  = ctrl_pkg::ALUOP_BITS,
  parameter int SEXT_W   = ctrl_pkg::SEXT_BITS
);
  logic                id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_W-1:0]    id_rn;
  logic [REG_W-1:0]    id_rm;
  logic [REG_W-1:0]    id_rt;
  logic [REG_W-1:0]    ex_rd;
  logic                mem_branch_taken;

  logic                id_reg2loc;
  logic                ex_alusrc;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [SEXT_W-1:0]   ex_sext;
  logic                mem_branch;
  logic                mem_ubranch;
  logic                mem_read;
  logic                mem_write;
  logic                wb_memtoreg;
  logic                wb_regwrite;
  logic                pc_write_en;
  logic                ifid_write_en;
  logic                ifid_flush;
  logic                illegal;

  modport master (
    output id_valid, id_opcode, id_rn, id_rm, id_rt, ex_rd, mem_branch_taken,
    input  id_reg2loc, ex_alusrc, ex_aluop, ex_sext, mem_branch, mem_ubranch,
           mem_read, mem_write, wb_memtoreg, wb_regwrite, pc_write_en,
           ifid_write_en, ifid_flush, illegal
  );

  modport slave (
    input  id_valid, id_opcode, id_rn, id_rm, id_rt, ex_rd, mem_branch_taken,
    output id_reg2loc, ex_alusrc, ex_aluop, ex_sext, mem_branch, mem_ubranch,
           mem_read, mem_write, wb_memtoreg, wb_regwrite, pc_write_en,
           ifid_write_en, ifid_flush, illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control decoder, shared with the single-cycle path.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic             valid,
  input  logic [OPC_W-1:0] opcode,
  output id_ctrl_t         ctrl
);

  always_comb begin
    ctrl = ID_BUBBLE;
    if (!valid || opcode == '0)
      ctrl = ID_BUBBLE;
    else if (opc_is(opcode, OP_ADD,  CARE_FULL)) ctrl = ctrl_word(1'b0, 1'b0, ALU_ADD,   SEXT_I,     F_RW);
    else if (opc_is(opcode, OP_SUB,  CARE_FULL)) ctrl = ctrl_word(1'b0, 1'b0, ALU_SUB,   SEXT_I,     F_RW);
    else if (opc_is(opcode, OP_AND,  CARE_FULL)) ctrl = ctrl_word(1'b0, 1'b0, ALU_AND,   SEXT_I,     F_RW);
    else if (opc_is(opcode, OP_ORR,  CARE_FULL)) ctrl = ctrl_word(1'b0, 1'b0, ALU_ORR,   SEXT_I,     F_RW);
    else if (opc_is(opcode, OP_ADDI, CARE_I))    ctrl = ctrl_word(1'b0, 1'b1, ALU_ADD,   SEXT_I,     F_RW);
    else if (opc_is(opcode, OP_SUBI, CARE_I))    ctrl = ctrl_word(1'b0, 1'b1, ALU_SUB,   SEXT_I,     F_RW);
    else if (opc_is(opcode, OP_LDUR, CARE_FULL)) ctrl = ctrl_word(1'b0, 1'b1, ALU_ADD,   SEXT_D,     F_LD);
    else if (opc_is(opcode, OP_STUR, CARE_FULL)) ctrl = ctrl_word(1'b1, 1'b1, ALU_ADD,   SEXT_D,     F_ST);
    else if (opc_is(opcode, OP_LSR,  CARE_FULL)) ctrl = ctrl_word(1'b0, 1'b1, ALU_LSR,   SEXT_SHAMT, F_RW);
    else if (opc_is(opcode, OP_LSL,  CARE_FULL)) ctrl = ctrl_word(1'b0, 1'b1, ALU_LSL,   SEXT_SHAMT, F_RW);
    else if (opc_is(opcode, OP_CBZ,  CARE_CB))   ctrl = ctrl_word(1'b1, 1'b0, ALU_PASSB, SEXT_CB,    F_CB);
    else if (opc_is(opcode, OP_B,    CARE_B))    ctrl = ctrl_word(1'b0, 1'b0, ALU_ADD,   SEXT_B,     F_B);
    else
      ctrl.ex.illegal = 1'b1;
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall and taken-branch flush.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W  = OPC_W,
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = ALUOP_BITS,
  parameter int SEXT_W    = SEXT_BITS,
  parameter bit HAZARD_EN = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  ctrl_pipe_unit_if.slave bus
);

  localparam logic [REG_W-1:0] XZR = '1;

  logic [OPCODE_W-1:0] opcode;
  id_ctrl_t            id_ctrl;
  ex_ctrl_t            ex_q;
  mem_ctrl_t           mem_q;
  wb_ctrl_t            wb_q;
  logic                flush;
  logic                stall;
  logic                use_src2;
  logic [REG_W-1:0]    src2;

  assign opcode = bus.id_opcode;

  ctrl_decode u_decode (
    .valid  (bus.id_valid),
    .opcode (OPC_W'(opcode)),
    .ctrl   (id_ctrl)
  );

  // Only R-type, STUR and CBZ read a second register; I/shift forms carry
  // immediate bits in the rm field.
  assign use_src2 = id_ctrl.reg2loc | (~id_ctrl.ex.alusrc & id_ctrl.ex.mem.wb.regwrite);
  assign src2     = id_ctrl.reg2loc ? bus.id_rt : bus.id_rm;
  assign flush    = bus.mem_branch_taken;

  // A flush discards the stalled instruction anyway, so it overrides the stall.
  assign stall = HAZARD_EN && !flush && bus.id_valid && ex_q.mem.memread &&
                 (bus.ex_rd != XZR) &&
                 ((bus.ex_rd == bus.id_rn) || (use_src2 && (bus.ex_rd == src2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= EX_BUBBLE;
      mem_q <= MEM_BUBBLE;
      wb_q  <= WB_BUBBLE;
    end else begin
      ex_q  <= (flush || stall) ? EX_BUBBLE : id_ctrl.ex;
      mem_q <= flush ? MEM_BUBBLE : ex_q.mem;
      wb_q  <= mem_q.wb;
    end
  end

  assign bus.id_reg2loc    = id_ctrl.reg2loc;
  assign bus.ex_alusrc     = ex_q.alusrc;
  assign bus.ex_aluop      = ALUOP_W'(ex_q.aluop);
  assign bus.ex_sext       = SEXT_W'(ex_q.sext);
  assign bus.illegal       = ex_q.illegal;
  assign bus.mem_branch    = mem_q.branch;
  assign bus.mem_ubranch   = mem_q.ubranch;
  assign bus.mem_read      = mem_q.memread;
  assign bus.mem_write     = mem_q.memwrite;
  assign bus.wb_memtoreg   = wb_q.memtoreg;
  assign bus.wb_regwrite   = wb_q.regwrite;
  assign bus.pc_write_en   = ~stall;
  assign bus.ifid_write_en = ~stall;
  assign bus.ifid_flush    = flush;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: reset, load-use stall, flush, flush+stall
// and a full decode sweep on a hazard-enabled and a hazard-disabled instance.
module tb_ctrl_pipe_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  ctrl_pipe_unit_if bus ();
  ctrl_pipe_unit_if bus_nh ();

  ctrl_pipe_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ctrl_pipe_unit #(.HAZARD_EN(1'b0)) u_dut_nh (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nh)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;

  logic [7:0]  obs_ex;
  logic [3:0]  obs_mem;
  logic [1:0]  obs_wb;
  assign obs_ex  = {bus.ex_alusrc, bus.ex_aluop, bus.ex_sext, bus.illegal};
  assign obs_mem = {bus.mem_branch, bus.mem_ubranch, bus.mem_read, bus.mem_write};
  assign obs_wb  = {bus.wb_memtoreg, bus.wb_regwrite};

  // Expected word: {reg2loc, alusrc, aluop[3], sext[3], branch, ubranch,
  //                 memread, memwrite, memtoreg, regwrite, illegal}
  localparam int NSW = 15;
  logic [10:0] sw_op  [NSW];
  logic        sw_v   [NSW];
  logic [14:0] sw_exp [NSW];
  logic [14:0] e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [10:0] op, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [4:0] rt, input logic [4:0] erd,
                       input logic bt);
    bus.id_valid = v;     bus_nh.id_valid = v;
    bus.id_opcode = op;   bus_nh.id_opcode = op;
    bus.id_rn = rn;       bus_nh.id_rn = rn;
    bus.id_rm = rm;       bus_nh.id_rm = rm;
    bus.id_rt = rt;       bus_nh.id_rt = rt;
    bus.ex_rd = erd;      bus_nh.ex_rd = erd;
    bus.mem_branch_taken = bt;
    bus_nh.mem_branch_taken = bt;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 5'd31, 1'b0);
      step();
    end
  endtask

  initial begin
    sw_op  = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
               11'b10010001000, 11'b11010001001, 11'b11111000010, 11'b11111000000,
               11'b11010011010, 11'b11010011011, 11'b10110100101, 11'b00010111010,
               11'b00000000000, 11'b11111111111, 11'b10001011000};
    sw_v   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    sw_exp = '{15'b0_0_000_000_0_0_0_0_0_1_0,   // ADD
               15'b0_0_001_000_0_0_0_0_0_1_0,   // SUB
               15'b0_0_010_000_0_0_0_0_0_1_0,   // AND
               15'b0_0_011_000_0_0_0_0_0_1_0,   // ORR
               15'b0_1_000_000_0_0_0_0_0_1_0,   // ADDI
               15'b0_1_001_000_0_0_0_0_0_1_0,   // SUBI (lsb set)
               15'b0_1_000_001_0_0_1_0_1_1_0,   // LDUR
               15'b1_1_000_001_0_0_0_1_0_0_0,   // STUR
               15'b0_1_100_010_0_0_0_0_0_1_0,   // LSR
               15'b0_1_101_010_0_0_0_0_0_1_0,   // LSL
               15'b1_0_110_011_1_0_0_0_0_0_0,   // CBZ
               15'b0_0_000_100_0_1_0_0_0_0_0,   // B
               15'b0_0_000_000_0_0_0_0_0_0_0,   // all-zero opcode
               15'b0_0_000_000_0_0_0_0_0_0_1,   // 0x7FF illegal
               15'b0_0_000_000_0_0_0_0_0_0_0};  // ADD with id_valid=0

    // Reset held 3 cycles with ADD in ID
    rst_n = 1'b0;
    drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 5'd31, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_stage_regs", {obs_ex, obs_mem, obs_wb}, 14'd0);
      check("rst_pc_we", bus.pc_write_en, 1'b1);
      check("rst_ifid_we", bus.ifid_write_en, 1'b1);
      check("rst_ifid_flush", bus.ifid_flush, 1'b0);
    end
    rst_n = 1'b1;
    step();
    check("rst_rel_ex_aluop", bus.ex_aluop, 3'b000);
    step();
    step();
    check("rst_rel_wb_regwrite", bus.wb_regwrite, 1'b1);
    idle(4);

    // Load-use: LDUR X2 ; ADD X3,X2,X4
    drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2, 5'd31, 1'b0);
    check("lu_c0_pc_we", bus.pc_write_en, 1'b1);
    step();
    drive(1'b1, OP_ADD, 5'd2, 5'd4, 5'd3, 5'd2, 1'b0);
    check("lu_stall_pc_we", bus.pc_write_en, 1'b0);
    check("lu_stall_ifid_we", bus.ifid_write_en, 1'b0);
    check("lu_nohaz_pc_we", bus_nh.pc_write_en, 1'b1);
    step();
    drive(1'b1, OP_ADD, 5'd2, 5'd4, 5'd3, 5'd31, 1'b0);
    check("lu_c2_pc_we", bus.pc_write_en, 1'b1);
    check("lu_c2_ex_bubble", obs_ex, 8'd0);
    check("lu_c2_mem_read", bus.mem_read, 1'b1);
    step();
    drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 5'd3, 1'b0);
    check("lu_c3_mem_bubble", obs_mem, 4'd0);
    check("lu_c3_wb_load", obs_wb, 2'b11);
    step();
    check("lu_c4_wb_bubble", bus.wb_regwrite, 1'b0);
    step();
    check("lu_c5_wb_add", obs_wb, 2'b01);
    idle(3);

    // No stall when the load targets XZR
    drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd31, 5'd31, 1'b0);
    step();
    drive(1'b1, OP_ADD, 5'd31, 5'd1, 5'd5, 5'd31, 1'b0);
    check("xzr_pc_we", bus.pc_write_en, 1'b1);
    step();
    drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0);
    step();
    step();
    check("xzr_wb_add", obs_wb, 2'b01);
    idle(3);

    // No stall for ADDI whose immediate bits alias X2 in the rm field
    drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2, 5'd31, 1'b0);
    step();
    drive(1'b1, OP_ADDI, 5'd7, 5'd2, 5'd6, 5'd2, 1'b0);
    check("addi_pc_we", bus.pc_write_en, 1'b1);
    check("addi_ifid_we", bus.ifid_write_en, 1'b1);
    step();
    idle(4);

    // Branch flush: CBZ ; ADD ; SUB, taken while CBZ in MEM
    drive(1'b1, OP_CBZ, 5'd0, 5'd0, 5'd1, 5'd31, 1'b0);
    step();
    drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 5'd31, 1'b0);
    check("fl_c1_ifid_flush", bus.ifid_flush, 1'b0);
    step();
    drive(1'b1, OP_SUB, 5'd4, 5'd5, 5'd6, 5'd3, 1'b1);
    check("fl_ifid_flush", bus.ifid_flush, 1'b1);
    check("fl_mem_branch", bus.mem_branch, 1'b1);
    check("fl_pc_we", bus.pc_write_en, 1'b1);
    step();
    drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 5'd31, 1'b0);
    check("fl_c3_ex_bubble", obs_ex, 8'd0);
    check("fl_c3_mem_bubble", obs_mem, 4'd0);
    check("fl_c3_wb_cbz", obs_wb, 2'b00);
    step();
    check("fl_c4_wb_add_slot", bus.wb_regwrite, 1'b0);
    step();
    check("fl_c5_wb_sub_slot", bus.wb_regwrite, 1'b0);
    idle(3);

    // Flush and load-use stall in the same cycle
    drive(1'b1, OP_CBZ, 5'd0, 5'd0, 5'd1, 5'd31, 1'b0);
    step();
    drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2, 5'd31, 1'b0);
    step();
    drive(1'b1, OP_ADD, 5'd2, 5'd4, 5'd3, 5'd2, 1'b1);
    check("fs_pc_we", bus.pc_write_en, 1'b1);
    check("fs_ifid_flush", bus.ifid_flush, 1'b1);
    check("fs_nohaz_pc_we", bus_nh.pc_write_en, 1'b1);
    step();
    drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 5'd31, 1'b0);
    check("fs_c3_ex_bubble", obs_ex, 8'd0);
    check("fs_c3_mem_read", bus.mem_read, 1'b0);
    check("fs_c3_wb_cbz", bus.wb_regwrite, 1'b0);
    step();
    check("fs_c4_wb_ld_slot", obs_wb, 2'b00);
    step();
    check("fs_c5_wb_add_slot", bus.wb_regwrite, 1'b0);
    idle(3);

    // Decode sweep, back-to-back through all three stages
    for (int k = 0; k < NSW + 3; k++) begin
      if (k < NSW) drive(sw_v[k], sw_op[k], 5'd0, 5'd0, 5'd0, 5'd31, 1'b0);
      else         drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 5'd31, 1'b0);
      if (k < NSW) check($sformatf("id_reg2loc[%0d]", k), bus.id_reg2loc, sw_exp[k][14]);
      check($sformatf("nohaz_pc_we[%0d]", k), bus_nh.pc_write_en, 1'b1);
      if (k >= 1 && k <= NSW) begin
        e = sw_exp[k-1];
        check($sformatf("ex_bundle[%0d]", k-1), obs_ex, {e[13], e[12:10], e[9:7], e[0]});
      end
      if (k >= 2 && k <= NSW + 1) begin
        e = sw_exp[k-2];
        check($sformatf("mem_bundle[%0d]", k-2), obs_mem, e[6:3]);
      end
      if (k >= 3) begin
        e = sw_exp[k-3];
        check($sformatf("wb_bundle[%0d]", k-3), obs_wb, e[2:1]);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Next-generation control unit for the segmented ARMv8 core.
- Decodes the 11-bit opcode in ID into the control bundle, then carries that bundle through the ID/EX, EX/MEM and MEM/WB stage registers.
- Adds three things the combinational decoder lacked: CBZ/B decode, load-use hazard stall, and branch flush.
- Sits between the IF/ID register and the datapath stage registers, and drives PC and IF/ID write enables.

Parameters:
- OPCODE_W, 11: opcode field width.
- REG_W, 5: register address width.
- ALUOP_W, 3: ALU operation code width.
- SEXT_W, 3: sign-extend mode width.
- HAZARD_EN, 1: 1 = load-use stall active; 0 = stall logic tied off (`pc_write_en` is constant 1).

Ports:
- `clk`, in, 1: core clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `id_valid`, in, 1: IF/ID register holds a real instruction.
- `id_opcode`, in, OPCODE_W: instr[31:21].
- `id_rn`, in, REG_W: instr[9:5].
- `id_rm`, in, REG_W: instr[20:16].
- `id_rt`, in, REG_W: instr[4:0].
- `ex_rd`, in, REG_W: destination register of the instruction now in EX.
- `mem_branch_taken`, in, 1: branch resolved taken in MEM.
- `id_reg2loc`, out, 1: ID-stage register-file read select (combinational).
- `ex_alusrc`, out, 1: ALU B-operand select, EX stage.
- `ex_aluop`, out, ALUOP_W: ALU operation, EX stage.
- `ex_sext`, out, SEXT_W: sign-extend mode, EX stage.
- `mem_branch`, out, 1: conditional branch (CBZ), MEM stage.
- `mem_ubranch`, out, 1: unconditional branch (B), MEM stage.
- `mem_read`, out, 1: data-memory read, MEM stage.
- `mem_write`, out, 1: data-memory write, MEM stage.
- `wb_memtoreg`, out, 1: write-back source select, WB stage.
- `wb_regwrite`, out, 1: register-file write enable, WB stage.
- `pc_write_en`, out, 1: PC may advance.
- `ifid_write_en`, out, 1: IF/ID register may load.
- `ifid_flush`, out, 1: IF/ID register must be cleared.
- `illegal`, out, 1: undecodable opcode in EX (registered).

Behaviour:
- Reset: `rst_n` low asynchronously clears all stage registers to a bubble (all control bits 0, `illegal` 0). After reset `pc_write_en`=1, `ifid_write_en`=1, `ifid_flush`=0.
- Decode (casex, combinational, ID stage):
  - ADD 10001011000: aluop 000, regwrite.
  - SUB 11001011000: aluop 001, regwrite.
  - AND 10001010000: aluop 010, regwrite.
  - ORR 10101010000: aluop 011, regwrite.
  - ADDI 1001000100x: alusrc, aluop 000, sext 000, regwrite.
  - SUBI 1101000100x: alusrc, aluop 001, sext 000, regwrite.
  - LDUR 11111000010: alusrc, aluop 000, sext 001, memread, memtoreg, regwrite.
  - STUR 11111000000: reg2loc, alusrc, aluop 000, sext 001, memwrite.
  - LSR 11010011010: alusrc, aluop 100, sext 010, regwrite.
  - LSL 11010011011: alusrc, aluop 101, sext 010, regwrite.
  - CBZ 10110100xxx: reg2loc, aluop 110 (pass B), sext 011, branch.
  - B 000101xxxxx: sext 100, ubranch.
  - All-zero opcode: bubble, not illegal.
  - Any other opcode: bubble with `illegal`=1.
  - `id_valid`=0 forces a bubble.
- Pipeline: one register per boundary. A bundle decoded in cycle N appears on `ex_*` in N+1, on `mem_*` in N+2, on `wb_*` in N+3. Each stage drops the fields it has consumed.
- Load-use hazard (HAZARD_EN=1): stall when the EX-stage memread is 1 AND `ex_rd`≠31 AND (`ex_rd`==`id_rn` OR `ex_rd`==second source). The second source is `id_rt` when reg2loc=1, otherwise `id_rm`. The second-source compare is skipped for immediate/shift forms and B.
- Stall response:
  - `pc_write_en`=0 and `ifid_write_en`=0, combinationally in the same cycle.
  - Next edge loads a bubble into ID/EX; EX/MEM and MEM/WB advance normally.
  - A stall lasts exactly 1 cycle, because the load leaves EX.
- Flush: when `mem_branch_taken`=1:
  - `ifid_flush`=1 combinationally.
  - Next edge loads bubbles into ID/EX and EX/MEM, squashing the two younger instructions.
  - MEM/WB takes the branch bundle normally. Branch and store bundles have regwrite=0.
- Flush and stall in the same cycle: flush wins; `pc_write_en`=1 so the target PC loads.
- Consecutive taken branches: cannot occur, since the younger branch is squashed.
- Register 31 (XZR) as destination never causes a stall.

Decomposition:
- Package `ctrl_pkg`: opcode constants and casex patterns; ALUOP and SEXT encodings; a control-bundle struct or localparam bit offsets; the bubble constant.
- Sub-module `ctrl_decode`: pure combinational opcode → bundle, reused by the legacy single-cycle path.
- Hazard and flush logic plus the stage registers stay in the top module.

Test Plan:
- Reset: hold `rst_n`=0 for 3 cycles with opcode ADD → all stage outputs 0, `pc_write_en`=1. ADD appears as `ex_aluop`=000 one cycle after release.
- Load-use: LDUR X2 then ADD X3,X2,X4 → `pc_write_en`=0 for exactly one cycle, then a bubble in EX (`ex_aluop`=000, no regwrite downstream). ADD reaches WB with `wb_regwrite`=1 four cycles after its first ID cycle.
- No false stall: LDUR X31 then ADD X5,X31,X1 → no stall. Separately, LDUR X2 then ADDI X6,X7,#4 → no stall.
- Branch flush: CBZ followed by ADD and SUB, with `mem_branch_taken`=1 while CBZ is in MEM → `ifid_flush`=1. The ADD and SUB bundles never reach MEM (`mem_write`/`mem_read`=0, `wb_regwrite`=0 in their slots).
- Flush and stall in the same cycle: force both conditions → `pc_write_en`=1, `ifid_flush`=1, both younger stages hold bubbles.
- Decode sweep: every listed opcode plus 0x7FF → bundle matches the table; 0x7FF sets `illegal`=1 in EX; opcode 0 sets `illegal`=0. Repeat with HAZARD_EN=0 → `pc_write_en` constant 1.
